// File: rtl/ct_pkg.sv
// Shared definitions for the ct_* conversion pipeline.
// State encoding for the registered skid buffer stage.
package ct_pkg;

  typedef enum logic [1:0] {
    CT_EMPTY = 2'd0,
    CT_BUSY  = 2'd1,
    CT_FULL  = 2'd2
  } ct_pipe_state_t;

endpackage

// File: rtl/ct_pipe_reg.sv
// Two-entry registered skid buffer placed after ct_field_conv.
// Every output comes from a flop, so valid, ready and data are all cut.
module ct_pipe_reg
  import ct_pkg::*;
#(
  parameter int unsigned WD = 0,
  parameter int unsigned WF = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [WD-1:0] i_data,
  input  logic [WF-1:0] i_field,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [WD-1:0] o_data,
  output logic [WF-1:0] o_field,
  output logic          o_valid,
  input  logic          i_ready
);

  localparam int unsigned WP = WF + WD;

  ct_pipe_state_t state_q, state_d;
  logic [WP-1:0]  main_q, main_d;
  logic [WP-1:0]  skid_q, skid_d;
  logic [WP-1:0]  in_word;
  logic           valid_q, ready_q;
  logic           in_xfer, out_xfer;

  assign in_word  = {i_field, i_data};
  assign in_xfer  = i_valid && ready_q;
  assign out_xfer = valid_q && i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      CT_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_word;
          state_d = CT_BUSY;
        end
      end
      CT_BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = in_word;
        end else if (in_xfer) begin
          skid_d  = in_word;
          state_d = CT_FULL;
        end else if (out_xfer) begin
          state_d = CT_EMPTY;
        end
      end
      CT_FULL: begin
        // ready_q is low here, so only the drain side can move.
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = CT_BUSY;
        end
      end
      default: state_d = CT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CT_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= (state_d != CT_EMPTY);
      ready_q <= (state_d != CT_FULL);
    end
  end

  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_field = main_q[WP-1:WD];
  assign o_data  = main_q[WD-1:0];

`ifndef SYNTHESIS
  no_input_when_full: assert property (
    @(posedge clk) disable iff (!reset) (state_q == CT_FULL) |-> !in_xfer);

  stable_when_stalled: assert property (
    @(posedge clk) disable iff (!reset)
    (valid_q && !i_ready) |=> (valid_q && $stable(main_q)));
`endif

endmodule

// File: tb/tb_ct_pipe_reg.sv
// Directed and randomised checks of ct_pipe_reg with WD=8, WF=4.
module tb_ct_pipe_reg;
  import ct_pkg::*;

  localparam int unsigned WD = 8;
  localparam int unsigned WF = 4;
  localparam int NWORDS = 10000;

  logic          clk;
  logic          reset;
  logic [WD-1:0] i_data;
  logic [WF-1:0] i_field;
  logic          i_valid;
  logic          o_ready;
  logic [WD-1:0] o_data;
  logic [WF-1:0] o_field;
  logic          o_valid;
  logic          i_ready;

  int total;
  int bad;

  ct_pipe_reg #(
    .WD(WD),
    .WF(WF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_data (i_data),
    .i_field(i_field),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_field(o_field),
    .o_valid(o_valid),
    .i_ready(i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WF-1:0] f, input logic [WD-1:0] d);
    i_valid = v;
    i_field = f;
    i_data  = d;
  endtask

  logic [WF+WD-1:0] sb_q[$];
  logic [WF+WD-1:0] exp_word;
  int sent, rcvd, cyc;
  logic pend;

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    i_ready = 1'b0;
    drive(1'b0, '0, '0);

    // Reset then idle
    #3;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_field", 32'(o_field), 32'd0);
    repeat (2) cycle();
    reset = 1'b1;
    check("rel_ready_pre", 32'(o_ready), 32'd0);
    cycle();
    check("rel_ready_post", 32'(o_ready), 32'd1);
    repeat (3) cycle();
    check("idle_valid", 32'(o_valid), 32'd0);

    // Streaming with downstream always ready
    i_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        check("strm_valid", 32'(o_valid), 32'd1);
        check("strm_data", 32'(o_data), 32'(8'h10 + k - 1));
        check("strm_field", 32'(o_field), 32'(k));
        check("strm_ready", 32'(o_ready), 32'd1);
      end
      if (k < 8) drive(1'b1, WF'(k + 1), WD'(8'h10 + k));
      else drive(1'b0, '0, '0);
      cycle();
    end
    check("strm_drain", 32'(o_valid), 32'd0);

    // Stall: fill main and skid, then release
    i_ready = 1'b0;
    drive(1'b1, 4'd1, 8'hA1);
    cycle();
    check("stl_busy_data", 32'(o_data), 32'hA1);
    check("stl_busy_ready", 32'(o_ready), 32'd1);
    drive(1'b1, 4'd2, 8'hA2);
    cycle();
    drive(1'b0, '0, '0);
    check("stl_full_ready", 32'(o_ready), 32'd0);
    check("stl_full_state", 32'(dut.state_q), 32'(CT_FULL));
    check("stl_full_data", 32'(o_data), 32'hA1);
    cycle();
    check("stl_hold_data", 32'(o_data), 32'hA1);
    check("stl_hold_ready", 32'(o_ready), 32'd0);
    i_ready = 1'b1;
    cycle();
    check("stl_out2_data", 32'(o_data), 32'hA2);
    check("stl_out2_field", 32'(o_field), 32'd2);
    check("stl_out2_ready", 32'(o_ready), 32'd1);
    cycle();
    check("stl_empty", 32'(o_valid), 32'd0);

    // Simultaneous in/out while BUSY
    i_ready = 1'b0;
    drive(1'b1, 4'd4, 8'h44);
    cycle();
    check("sim_first", 32'(o_data), 32'h44);
    i_ready = 1'b1;
    drive(1'b1, 4'd5, 8'h55);
    cycle();
    drive(1'b0, '0, '0);
    check("sim_data", 32'(o_data), 32'h55);
    check("sim_field", 32'(o_field), 32'd5);
    check("sim_state", 32'(dut.state_q), 32'(CT_BUSY));
    check("sim_ready", 32'(o_ready), 32'd1);
    cycle();
    check("sim_drain", 32'(o_valid), 32'd0);

    // Reset while FULL discards both held words
    i_ready = 1'b0;
    drive(1'b1, 4'd1, 8'hA1);
    cycle();
    drive(1'b1, 4'd2, 8'hA2);
    cycle();
    drive(1'b0, '0, '0);
    check("rf_full", 32'(o_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("rf_async_valid", 32'(o_valid), 32'd0);
    check("rf_async_data", 32'(o_data), 32'd0);
    cycle();
    reset = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("rf_no_stale", 32'(o_valid), 32'd0);
    end
    check("rf_ready", 32'(o_ready), 32'd1);

    // Random valid/ready with scoreboard
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    pend = 1'b0;
    while (rcvd < NWORDS && cyc < 60000) begin
      if (!pend) begin
        if (sent < NWORDS && $urandom_range(3) != 0)
          drive(1'b1, WF'(sent >> 8), WD'(sent));
        else
          drive(1'b0, '0, '0);
      end
      i_ready = ($urandom_range(3) != 0);
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          check("rnd_spurious", 32'(o_valid), 32'd0);
        end else begin
          exp_word = sb_q.pop_front();
          check("rnd_word", 32'({o_field, o_data}), 32'(exp_word));
          rcvd++;
        end
      end
      if (i_valid && o_ready) begin
        sb_q.push_back({i_field, i_data});
        sent++;
        pend = 1'b0;
      end else begin
        pend = i_valid;
      end
      cycle();
      cyc++;
    end
    drive(1'b0, '0, '0);
    check("rnd_count", 32'(rcvd), 32'(NWORDS));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_pipe_reg.md
# ct_pipe_reg

Registered two-entry skid buffer that sits directly downstream of the `ct_field_conv` stage. It captures the converted field plus passthrough data and presents both to the next consumer from flops. This breaks the combinational valid/ready/data path through the conversion mux while sustaining one transfer per cycle. Insertion is optional per link; the block is transparent to contents and ordering.

## Interface
- `WD`, default 0: passthrough data width, excluding field; legal ≥1 at instantiation.
- `WF`, default 0: field width, equal to the upstream converter's output field width; legal ≥1.
- `clk` input 1: sole clock; all state on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `i_data` input WD: data from upstream.
- `i_field` input WF: converted field from upstream.
- `i_valid` input 1: upstream word valid.
- `o_ready` output 1: block can accept; driven directly from a flop.
- `o_data` output WD: registered data to downstream.
- `o_field` output WF: registered field to downstream.
- `o_valid` output 1: downstream word valid; driven directly from a flop.
- `i_ready` input 1: downstream accepts.

## Operation
- Input transfer: `i_valid && o_ready`. Output transfer: `o_valid && i_ready`.
- Storage:
  - Main slot: drives `o_data`, `o_field` and `o_valid`.
  - Skid slot: holds one word, field and data together.
- States (enum `ct_pipe_state_t`): EMPTY, BUSY (main slot only), FULL (main and skid).
- EMPTY:
  - Input transfer → main ← input; go to BUSY.
  - Otherwise stay.
- BUSY:
  - Input and output transfer together → main ← input; stay BUSY.
  - Input only → skid ← input; go to FULL.
  - Output only → go to EMPTY.
  - Neither → hold.
- FULL:
  - `o_ready`=0, so no input transfer occurs.
  - Output transfer → main ← skid; go to BUSY.
  - Otherwise hold.
- Outputs and flags:
  - `o_valid` = state ≠ EMPTY, registered.
  - `o_ready` = state ≠ FULL, registered.
  - Both are computed from the next state, so they are valid in the cycle after the transition.
- Ordering: strict FIFO; no word is dropped, duplicated or reordered.
- Upstream contract: upstream holds `i_valid`, `i_data` and `i_field` stable while `i_valid && !o_ready`.
- Downstream contract: the block holds its outputs stable while `o_valid && !i_ready`.
- Contents are not inspected; field values pass unmodified.
- Simulation-only assertions:
  - No input transfer while FULL.
  - Outputs stable while stalled.
  - Both are disabled while `reset` is low.

## Timing
- Reset asserted (`reset`=0), asynchronously:
  - state=EMPTY.
  - `o_valid`=0, `o_ready`=0.
  - `o_data`=0, `o_field`=0, skid=0.
- First rising edge after `reset` deasserts: `o_ready` becomes 1. No input is accepted before that edge.
- Latency: a word accepted at edge N appears on `o_valid`/`o_data` after edge N; the earliest output transfer is at edge N+1.
- Throughput: one word per cycle while downstream is always ready; the block stays in BUSY.
- Backpressure: after `i_ready` drops, at most one further input is accepted (into skid) before `o_ready` falls at the next edge.
- Release: the first output transfer from FULL re-raises `o_ready` after that edge, with skid contents moved to main in the same edge.
- Reset mid-operation: all held words are discarded immediately; there is no partial output after reset release.
- No combinational path from any input to any output.

## Structure
- Shared package `ct_pkg`: enum `ct_pipe_state_t` {CT_EMPTY, CT_BUSY, CT_FULL}, 2-bit encoding.
- No sub-module: one state register, two payload registers, and the next-state logic in a single module.
- Payload packing: `{field, data}` concatenated to width WF+WD internally. The same packing is used by any future multi-stage wrapper.

## Test plan
- Reset then idle, WD=8, WF=4:
  - Outputs 0 during reset.
  - `o_ready`=1 one edge after release.
  - `o_valid` stays 0 with `i_valid`=0.
- Streaming, `i_ready`=1: inputs field 1..8 / data 0x10..0x17 on consecutive cycles → identical sequence on outputs, each 1 cycle later, no bubbles.
- Stall:
  - Push 0xA1 then 0xA2 with `i_ready`=0 → state FULL, `o_ready`=0, `o_data`=0xA1 held.
  - Raise `i_ready` → 0xA1 then 0xA2 out on consecutive cycles; `o_ready` back to 1 after the first.
- Random `i_valid`/`i_ready`, 10k words → scoreboard confirms exact order, no loss, assertions clean.
- Reset asserted while FULL → `o_valid` drops asynchronously, and no stale 0xA1/0xA2 appears after release.
- Simultaneous transfer in BUSY, with input 0x55 and output of 0x44 at the same edge → `o_data`=0x55 next cycle, state BUSY.
